// File: rtl/btn_irq_ctrl.sv
// Button interrupt controller: sync, debounce, edge-to-pending, fixed-priority claim/complete.
// Define BTN_DEBOUNCE_EN to include the per-source debounce counters.
module btn_irq_ctrl #(
    parameter int unsigned NUM_SRC         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    localparam int unsigned IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SRC-1:0] i_io_btn,
    input  logic               i_irq_en,
    input  logic [NUM_SRC-1:0] i_mask,
    input  logic               i_ack,
    input  logic               i_eoi,
    output logic               o_irq,
    output logic [IDW-1:0]     o_irq_id,
    output logic [NUM_SRC-1:0] o_pending,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
        $error("btn_irq_ctrl: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [NUM_SRC-1:0] sync1_q, sync1_d;
    logic [NUM_SRC-1:0] sync2_q, sync2_d;
    logic [NUM_SRC-1:0] deb_prev_q, deb_prev_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] deb_lvl;
    logic [NUM_SRC-1:0] edge_c;
    logic [NUM_SRC-1:0] elig_c;
    logic [NUM_SRC-1:0] clr_c;
    logic [IDW-1:0]     win_id_c;
    logic               any_c;

    state_t             state_q, state_d;
    logic               irq_q, irq_d;
    logic               busy_q, busy_d;
    logic [IDW-1:0]     irq_id_q, irq_id_d;

`ifdef BTN_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

    logic [NUM_SRC-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NUM_SRC-1:0]         deb_q, deb_d;

    // Count consecutive disagreeing cycles; flip the level after DEBOUNCE_CYCLES of them.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = ~deb_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
            deb_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign deb_lvl = deb_q;
`else
    assign deb_lvl = sync2_q;
`endif

    assign edge_c = deb_lvl & ~deb_prev_q;
    assign elig_c = i_irq_en ? (pending_q & i_mask) : '0;

    // Highest eligible index wins.
    always_comb begin
        win_id_c = '0;
        any_c    = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (elig_c[i]) begin
                win_id_c = IDW'(i);
                any_c    = 1'b1;
            end
        end
    end

    // Input pipeline and sticky pending; a new edge wins over a same-cycle claim.
    always_comb begin
        sync1_d    = i_io_btn;
        sync2_d    = sync1_q;
        deb_prev_d = deb_lvl;
        pending_d  = (pending_q & ~clr_c) | edge_c;
    end

    always_comb begin
        state_d  = state_q;
        irq_d    = 1'b0;
        busy_d   = 1'b0;
        irq_id_d = irq_id_q;
        clr_c    = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_c) begin
                    state_d  = ST_REQ;
                    irq_d    = 1'b1;
                    irq_id_d = win_id_c;
                end
            end
            ST_REQ: begin
                if (i_ack) begin
                    state_d          = ST_SERVICE;
                    busy_d           = 1'b1;
                    clr_c[irq_id_q]  = 1'b1;
                end else if (!any_c) begin
                    state_d = ST_IDLE;
                end else begin
                    irq_d    = 1'b1;
                    irq_id_d = win_id_c;
                end
            end
            ST_SERVICE: begin
                if (i_eoi) begin
                    state_d = ST_IDLE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_prev_q <= '0;
            pending_q  <= '0;
            state_q    <= ST_IDLE;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
            irq_id_q   <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_prev_q <= deb_prev_d;
            pending_q  <= pending_d;
            state_q    <= state_d;
            irq_q      <= irq_d;
            busy_q     <= busy_d;
            irq_id_q   <= irq_id_d;
        end
    end

    assign o_irq     = irq_q;
    assign o_irq_id  = irq_id_q;
    assign o_pending = pending_q;
    assign o_busy    = busy_q;

endmodule
